// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: CPU opcode encodings,
// handshake FSM state encoding and the signed add/sub overflow rule.
package alu_pkg;

    localparam logic [2:0] OP_LOAD    = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_ADDI    = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_SUBI    = 3'b100;
    localparam logic [2:0] OP_MUL     = 3'b101;
    localparam logic [2:0] OP_CLEAR   = 3'b110;
    localparam logic [2:0] OP_DISPLAY = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EXEC_MUL = 2'd1,
        S_DONE     = 2'd2
    } state_t;

    // Two's complement overflow from the sign bits only, so it works for any width.
    // Add overflows when both operands share a sign and the result does not.
    // Subtract overflows when the operand signs differ and the result sign leaves a's sign.
    function automatic logic addSubOverflow(input logic aSign,
                                            input logic bSign,
                                            input logic rSign,
                                            input logic isSub);
        return isSub ? ((aSign != bSign) && (rSign != aSign))
                     : ((aSign == bSign) && (rSign != aSign));
    endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Iterative unsigned shift-add multiplier: one partial product per clock,
// always exactly WIDTH iterations after a start pulse, no early exit.
module mul_shift_add #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] w_accNext;

    // Accumulator value after the current iteration; on the last iteration this is the full product.
    always_comb begin
        w_accNext = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    end

    // The final iteration's result is presented combinationally so the caller can register it on the same edge.
    assign o_done    = (r_cnt == CNT_W'(1));
    assign o_product = w_accNext;

    // Load operands on start, then shift the multiplicand left and the multiplier right once per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_cnt    <= CNT_W'(WIDTH);
        end else if (r_cnt != '0) begin
            r_acc    <= w_accNext;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_multiciclo.sv
// Handshaked multi-cycle ALU for the mini-CPU opcode set. Single-cycle ops
// finish on the accept edge; MUL runs through the shift-add unit. Result and
// flags are registered and held until the write-back stage takes them.
module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] valor1,
    input  logic [WIDTH-1:0] valor2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] resultado,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);

    state_t             r_state;
    logic [WIDTH-1:0]   r_resultado;
    logic               r_overflow;
    logic               r_zero;
    logic               r_outValid;
    logic               r_busy;

    logic               w_accept;
    logic               w_isMul;
    logic               w_mulStart;
    logic               w_mulDone;
    logic [2*WIDTH-1:0] w_mulProduct;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_aluResult;
    logic               w_aluOverflow;

    // A new op may enter when idle, or when the held result is being consumed this same cycle.
    assign in_ready   = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_isMul    = (opcode == OP_MUL);
    assign w_mulStart = w_accept && w_isMul;

    assign w_sum  = valor1 + valor2;
    assign w_diff = valor1 - valor2;

    assign out_valid = r_outValid;
    assign resultado = r_resultado;
    assign overflow  = r_overflow;
    assign zero      = r_zero;
    assign busy      = r_busy;

    mul_shift_add #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_mulStart),
        .i_a      (valor1),
        .i_b      (valor2),
        .o_done   (w_mulDone),
        .o_product(w_mulProduct)
    );

    // Single-cycle datapath: result and overflow for every opcode except MUL.
    always_comb begin
        w_aluResult   = '0;
        w_aluOverflow = 1'b0;
        case (opcode)
            OP_LOAD: begin
                w_aluResult = valor2;
            end
            OP_ADD, OP_ADDI: begin
                w_aluResult   = w_sum;
                w_aluOverflow = addSubOverflow(valor1[WIDTH-1], valor2[WIDTH-1],
                                               w_sum[WIDTH-1], 1'b0);
            end
            OP_SUB, OP_SUBI: begin
                w_aluResult   = w_diff;
                w_aluOverflow = addSubOverflow(valor1[WIDTH-1], valor2[WIDTH-1],
                                               w_diff[WIDTH-1], 1'b1);
            end
            OP_DISPLAY: begin
                w_aluResult = valor1;
            end
            default: begin
                w_aluResult   = '0;
                w_aluOverflow = 1'b0;
            end
        endcase
    end

    // Handshake FSM with registered result, flags, out_valid and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_resultado <= '0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
            r_outValid  <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_accept) begin
            if (w_isMul) begin
                r_state    <= S_EXEC_MUL;
                r_busy     <= 1'b1;
                r_outValid <= 1'b0;
            end else begin
                r_state     <= S_DONE;
                r_resultado <= w_aluResult;
                r_overflow  <= w_aluOverflow;
                r_zero      <= (w_aluResult == '0);
                r_outValid  <= 1'b1;
            end
        end else begin
            case (r_state)
                S_EXEC_MUL: begin
                    if (w_mulDone) begin
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_resultado <= w_mulProduct[WIDTH-1:0];
                        r_overflow  <= |w_mulProduct[2*WIDTH-1:WIDTH];
                        r_zero      <= (w_mulProduct[WIDTH-1:0] == '0);
                        r_outValid  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state    <= S_IDLE;
                        r_outValid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed self-checking bench for alu_multiciclo at WIDTH=16.
module tb_alu_multiciclo;

    localparam int W = 16;

    localparam logic [2:0] LOAD    = 3'b000;
    localparam logic [2:0] ADD     = 3'b001;
    localparam logic [2:0] ADDI    = 3'b010;
    localparam logic [2:0] SUB     = 3'b011;
    localparam logic [2:0] SUBI    = 3'b100;
    localparam logic [2:0] MUL     = 3'b101;
    localparam logic [2:0] CLEAR   = 3'b110;
    localparam logic [2:0] DISPLAY = 3'b111;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   opcode;
    logic [W-1:0] valor1;
    logic [W-1:0] valor2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] resultado;
    logic         overflow;
    logic         zero;
    logic         busy;

    int errors = 0;
    int checks = 0;

    alu_multiciclo #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .valor1   (valor1),
        .valor2   (valor2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .resultado(resultado),
        .overflow (overflow),
        .zero     (zero),
        .busy     (busy)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operation for a single edge, then withdraw in_valid.
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
        in_valid = 1'b1;
        opcode   = op;
        valor1   = a;
        valor2   = b;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        bit sawValid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        opcode    = LOAD;
        valor1    = '0;
        valor2    = '0;

        step();
        step();
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_resultado", resultado, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_zero", zero, 0);
        checkOutput("rst_busy", busy, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", in_ready, 1);

        $display("[TB] basic add");
        applyStimulus(ADD, 16'h0005, 16'h0003);
        checkOutput("add_valid", out_valid, 1);
        checkOutput("add_res", resultado, 16'h0008);
        checkOutput("add_ovf", overflow, 0);
        checkOutput("add_zero", zero, 0);
        step();
        checkOutput("add_valid_drop", out_valid, 0);

        $display("[TB] overflow and zero flags");
        applyStimulus(ADD, 16'h7FFF, 16'h0001);
        checkOutput("addovf_res", resultado, 16'h8000);
        checkOutput("addovf_ovf", overflow, 1);
        step();
        applyStimulus(SUB, 16'h0004, 16'h0004);
        checkOutput("subz_res", resultado, 16'h0000);
        checkOutput("subz_zero", zero, 1);
        checkOutput("subz_ovf", overflow, 0);
        step();
        applyStimulus(SUBI, 16'h8000, 16'h0001);
        checkOutput("subovf_res", resultado, 16'h7FFF);
        checkOutput("subovf_ovf", overflow, 1);
        step();
        applyStimulus(ADD, 16'hFFFF, 16'h0001);
        checkOutput("addwrap_res", resultado, 16'h0000);
        checkOutput("addwrap_ovf", overflow, 0);
        checkOutput("addwrap_zero", zero, 1);
        step();

        $display("[TB] multiply latency");
        applyStimulus(MUL, 16'h0012, 16'h0010);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("mul_busy_%0d", i), busy, 1);
            checkOutput($sformatf("mul_inrdy_%0d", i), in_ready, 0);
            checkOutput($sformatf("mul_noval_%0d", i), out_valid, 0);
            step();
        end
        checkOutput("mul_valid", out_valid, 1);
        checkOutput("mul_busy_end", busy, 0);
        checkOutput("mul_res", resultado, 16'h0120);
        checkOutput("mul_ovf", overflow, 0);
        checkOutput("mul_zero", zero, 0);
        step();
        applyStimulus(MUL, 16'h0100, 16'h0100);
        for (int i = 0; i < 16; i++) step();
        checkOutput("mulbig_valid", out_valid, 1);
        checkOutput("mulbig_res", resultado, 16'h0000);
        checkOutput("mulbig_ovf", overflow, 1);
        checkOutput("mulbig_zero", zero, 1);
        step();

        $display("[TB] backpressure and back-to-back");
        out_ready = 1'b0;
        applyStimulus(ADDI, 16'h000A, 16'h0001);
        checkOutput("bp_res0", resultado, 16'h000B);
        in_valid = 1'b1;
        opcode   = SUBI;
        valor1   = 16'h000B;
        valor2   = 16'h0002;
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput($sformatf("bp_hold_res_%0d", i), resultado, 16'h000B);
            checkOutput($sformatf("bp_hold_val_%0d", i), out_valid, 1);
            checkOutput($sformatf("bp_inrdy_%0d", i), in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("b2b_inrdy", in_ready, 1);
        step();
        in_valid = 1'b0;
        checkOutput("b2b_valid", out_valid, 1);
        checkOutput("b2b_res", resultado, 16'h0009);
        checkOutput("b2b_ovf", overflow, 0);
        step();

        $display("[TB] reset during multiply");
        applyStimulus(MUL, 16'h0012, 16'h0010);
        for (int i = 0; i < 6; i++) step();
        checkOutput("mrst_busy_pre", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_busy", busy, 0);
        checkOutput("mrst_valid", out_valid, 0);
        checkOutput("mrst_res", resultado, 0);
        checkOutput("mrst_ovf", overflow, 0);
        checkOutput("mrst_zero", zero, 0);
        checkOutput("mrst_inrdy", in_ready, 1);
        step();
        rst_n = 1'b1;
        #1;
        checkOutput("mrst_inrdy_rel", in_ready, 1);
        sawValid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid !== 1'b0) sawValid = 1'b1;
        end
        checkOutput("mrst_no_valid", sawValid, 0);

        $display("[TB] pass-through ops");
        out_ready = 1'b0;
        applyStimulus(LOAD, 16'h5555, 16'hBEEF);
        checkOutput("load_res", resultado, 16'hBEEF);
        checkOutput("load_ovf", overflow, 0);
        checkOutput("load_zero", zero, 0);
        opcode = CLEAR;
        valor1 = 16'h0000;
        valor2 = 16'h0000;
        step();
        step();
        checkOutput("load_hold", resultado, 16'hBEEF);
        out_ready = 1'b1;
        step();
        applyStimulus(DISPLAY, 16'h1234, 16'hAAAA);
        checkOutput("disp_res", resultado, 16'h1234);
        checkOutput("disp_ovf", overflow, 0);
        step();
        applyStimulus(CLEAR, 16'h1111, 16'h2222);
        checkOutput("clr_res", resultado, 16'h0000);
        checkOutput("clr_zero", zero, 1);
        checkOutput("clr_ovf", overflow, 0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_multiciclo.md
Name: alu_multiciclo

Overview:
- Parametrised, handshaked successor to the mini-CPU ALU: executes the 3-bit CPU opcode set on WIDTH-bit operands.
- Registers its result and flags, and multiplies with an iterative shift-add unit.
- Sits between the register file/decoder (in_* side) and the write-back/display stage (out_* side).

Parameters:
WIDTH, 16, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH)+1, width of multiply iteration counter (derived, not overridden)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  opcode/operands valid
in_ready  output  1  block can accept an operation this cycle
opcode  input  3  LOAD=000 ADD=001 ADDI=010 SUB=011 SUBI=100 MUL=101 CLEAR=110 DISPLAY=111
valor1  input  WIDTH  operand A (register value)
valor2  input  WIDTH  operand B (register value or immediate, already selected by decoder)
out_valid  output  1  resultado/flags valid
out_ready  input  1  consumer accepts result
resultado  output  WIDTH  operation result
overflow  output  1  arithmetic overflow of held result
zero  output  1  resultado == 0
busy  output  1  high in EXEC_MUL

Behaviour:
- One clock; reset is asynchronous and active-low: rst_n=0 forces state IDLE, resultado=0, overflow=0, zero=0, out_valid=0, busy=0, counter=0, immediately and regardless of clk; mid-multiply reset aborts the operation with no output.
- States: IDLE, EXEC_MUL, DONE.
- Accept = in_valid && in_ready; in_ready = (state==IDLE) || (state==DONE && out_ready). Opcode/operands captured only on accept; later input changes ignored.
- From IDLE/DONE on accept: MUL -> EXEC_MUL; any other opcode -> DONE with result computed that edge (latency 1: out_valid high the cycle after accept).
- DONE && out_ready && !in_valid -> IDLE, out_valid drops next cycle. DONE && !out_ready: resultado/flags/out_valid held stable (no accept possible).
- Back-to-back: DONE && out_ready && accept -> new result overwrites at same edge; out_valid stays high (single-op-per-cycle throughput for non-MUL).
- Arithmetic (modulo 2^WIDTH, two's complement):
  - ADD/ADDI: a+b, overflow = signed overflow (operand signs equal, result sign differs).
  - SUB/SUBI: a-b, overflow = signed overflow (operand signs differ, result sign differs from a).
  - MUL: unsigned a*b, resultado = low WIDTH bits, overflow = (high WIDTH bits != 0).
  - LOAD: resultado=valor2, overflow=0. CLEAR: resultado=0, overflow=0. DISPLAY: resultado=valor1, overflow=0.
  - zero always = (resultado==0).
- EXEC_MUL: fixed WIDTH iterations, one per cycle (shift-add on 2*WIDTH accumulator), no early exit even when an operand is 0; busy=1, in_ready=0. After last iteration -> DONE. MUL latency: out_valid high WIDTH+1 cycles after accept.
- out_valid never asserted without a preceding accept since reset.

Decomposition:
- Package alu_pkg: opcode localparams (LOAD..DISPLAY), state enum encoding (IDLE/EXEC_MUL/DONE), function for signed add/sub overflow.
- Sub-module mul_shift_add (WIDTH): start pulse, a, b -> done pulse, 2*WIDTH product; owns the iteration counter. Top owns handshake FSM, add/sub/pass datapath, flag registers.

Test Plan (WIDTH=16):
1. Reset then ADD valor1=16'h0005 valor2=16'h0003, out_ready=1 -> one cycle later out_valid=1, resultado=16'h0008, overflow=0, zero=0; next cycle out_valid=0.
2. ADD 16'h7FFF+16'h0001 -> resultado=16'h8000, overflow=1; SUB 16'h0004-16'h0004 -> resultado=0, zero=1, overflow=0.
3. MUL 16'h0012*16'h0010 -> busy=1 for 16 cycles, in_ready=0 throughout, out_valid at cycle 17, resultado=16'h0120, overflow=0; MUL 16'h0100*16'h0100 -> resultado=0, overflow=1, zero=1.
4. Backpressure: ADDI 16'h000A,16'h0001 with out_ready=0 for 5 cycles -> resultado=16'h000B held stable, in_ready=0; raise out_ready with in_valid=1 SUBI 16'h000B,16'h0002 -> same edge accepted, next cycle resultado=16'h0009, out_valid continuous.
5. Reset mid-MUL: assert rst_n=0 at iteration 7 asynchronously -> all outputs 0 immediately, state IDLE, in_ready=1 after release, no out_valid.
6. LOAD valor2=16'hBEEF, DISPLAY valor1=16'h1234, CLEAR -> resultado 16'hBEEF, 16'h1234, 16'h0000 (zero=1), overflow=0 each; opcode changed while held in DONE does not alter resultado.
